// File: rtl/ask4_bcd_display_mux.sv
// Four-digit multiplexed BCD scan driver with frame-synchronous double buffering.
// Optional leading-zero blanking is enabled by defining ASK4_LZB_EN.
module ask4_bcd_display_mux #(
  parameter int unsigned REFRESH_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bcd_in,
  input  logic        load,
  input  logic        LED_type_ctl,
  output logic [3:0]  bcd_out,
  output logic [3:0]  digit_en,
  output logic [1:0]  digit_idx,
  output logic        bcd_err
);

  localparam logic [15:0] TC_VAL = 16'(REFRESH_DIV - 1);

  logic [15:0] pcnt_reg;
  logic [1:0]  idx_reg;
  logic [15:0] pend_reg;
  logic        pend_v_reg;
  logic [15:0] shadow_reg;
  logic        bcd_err_reg;
  logic [3:0]  bcd_out_reg;
  logic [3:0]  digit_en_reg;
  logic [1:0]  digit_idx_reg;

  logic        tc;
  logic        fb;
  logic        commit_en;
  logic [15:0] commit_val;
  logic [3:0]  commit_bad;
  logic [3:0]  digit_lit;
  logic [3:0]  nib [4];
  logic [3:0]  sel_nib;
  logic        sel_lit;
  logic [3:0]  sel_onehot;
  logic [3:0]  inactive_lvl;

  assign tc         = (pcnt_reg == TC_VAL);
  assign fb         = tc && (idx_reg == 2'd3);
  // A load coinciding with the frame boundary bypasses the pending buffer.
  assign commit_val = load ? bcd_in : pend_reg;
  assign commit_en  = fb && (load || pend_v_reg);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      logic blank;
      assign nib[gi]        = shadow_reg[4*gi +: 4];
      assign commit_bad[gi] = (commit_val[4*gi +: 4] > 4'd9);
`ifdef ASK4_LZB_EN
      if (gi == 0) begin : g_never_blank
        assign blank = 1'b0;
      end else begin : g_lzb
        assign blank = (shadow_reg[15:4*gi] == '0);
      end
`else
      assign blank = 1'b0;
`endif
      assign digit_lit[gi] = (nib[gi] <= 4'd9) && !blank;
    end
  endgenerate

  assign sel_nib      = nib[idx_reg];
  assign sel_lit      = digit_lit[idx_reg];
  assign sel_onehot   = 4'b0001 << idx_reg;
  assign inactive_lvl = {4{LED_type_ctl}};

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_reg      <= '0;
      idx_reg       <= '0;
      pend_reg      <= '0;
      pend_v_reg    <= 1'b0;
      shadow_reg    <= '0;
      bcd_err_reg   <= 1'b0;
      bcd_out_reg   <= 4'h0;
      digit_en_reg  <= inactive_lvl;
      digit_idx_reg <= 2'd0;
    end else begin
      pcnt_reg <= tc ? 16'd0 : pcnt_reg + 16'd1;
      if (tc) begin
        idx_reg <= idx_reg + 2'd1;
      end

      if (fb) begin
        if (commit_en) begin
          shadow_reg  <= commit_val;
          bcd_err_reg <= |commit_bad;
        end
        pend_v_reg <= 1'b0;
      end else if (load) begin
        pend_reg   <= bcd_in;
        pend_v_reg <= 1'b1;
      end

      // Outputs track the pre-edge scan state, giving one cycle of latency.
      bcd_out_reg   <= sel_lit ? sel_nib : 4'h0;
      digit_en_reg  <= sel_lit ? (inactive_lvl ^ sel_onehot) : inactive_lvl;
      digit_idx_reg <= idx_reg;
    end
  end

  assign bcd_out   = bcd_out_reg;
  assign digit_en  = digit_en_reg;
  assign digit_idx = digit_idx_reg;
  assign bcd_err   = bcd_err_reg;

endmodule

// File: tb/tb_ask4_bcd_display_mux.sv
// Directed bench for ask4_bcd_display_mux with REFRESH_DIV=4 (16-cycle frames).
module tb_ask4_bcd_display_mux;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] bcd_in;
  logic        load;
  logic        led;
  logic [3:0]  bcd_out;
  logic [3:0]  digit_en;
  logic [1:0]  digit_idx;
  logic        bcd_err;

  int n_cmp  = 0;
  int n_fail = 0;
  int k      = 0;
  logic [15:0] exp_val;
  logic        exp_err;

  always #5 clk = ~clk;

  ask4_bcd_display_mux #(.REFRESH_DIV(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .bcd_in       (bcd_in),
    .load         (load),
    .LED_type_ctl (led),
    .bcd_out      (bcd_out),
    .digit_en     (digit_en),
    .digit_idx    (digit_idx),
    .bcd_err      (bcd_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s k=%0d got=%h want=%h", tag, k, got, want);
    end
  endtask

  function automatic logic has_bad(input logic [15:0] v);
    logic bad = 1'b0;
    for (int d = 0; d < 4; d++) if (((v >> (4*d)) & 16'hF) > 16'd9) bad = 1'b1;
    return bad;
  endfunction

  // Expected digit_en/bcd_out for digit d of value v.
  task automatic model(input logic [15:0] v, input int d, input logic l,
                       output logic [3:0] en, output logic [3:0] nb);
    logic [3:0] n;
    logic       lit;
    n   = 4'((v >> (4*d)) & 16'hF);
    lit = (n <= 4'd9);
`ifdef ASK4_LZB_EN
    if (d > 0 && (v >> (4*d)) == 16'd0) lit = 1'b0;
`endif
    en = lit ? ({4{l}} ^ (4'b0001 << d)) : {4{l}};
    nb = lit ? n : 4'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    int d;
    logic [3:0] e_en, e_nb;
    tick();
    k++;
    d = ((k - 1) / 4) % 4;
    model(exp_val, d, led, e_en, e_nb);
    check("digit_idx", 32'(digit_idx), 32'(d));
    check("digit_en",  32'(digit_en),  32'(e_en));
    check("bcd_out",   32'(bcd_out),   32'(e_nb));
    check("bcd_err",   32'(bcd_err),   32'(exp_err));
  endtask

  task automatic cycles_to(input int t);
    while (k < t) cyc();
  endtask

  // Clock through the frame-boundary edge; bcd_err updates on it, digits one cycle later.
  task automatic frame_end(input logic [15:0] v);
    exp_err = has_bad(v);
    cyc();
    exp_val = v;
  endtask

  task automatic pulse_load(input logic [15:0] v);
    load = 1'b1; bcd_in = v;
    cyc();
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; bcd_in = 16'h0; led = 1'b1;
    exp_val = 16'h0; exp_err = 1'b0;
    tick(); tick();
    check("rst_en",  32'(digit_en),  32'h0000000F);
    check("rst_bcd", 32'(bcd_out),   32'h0);
    check("rst_idx", 32'(digit_idx), 32'h0);
    check("rst_err", 32'(bcd_err),   32'h0);
    reset = 1'b0;
    k = 0;

    cycles_to(1);
    check("first_en", 32'(digit_en), 32'h0000000E);
    cycles_to(5);
    pulse_load(16'h1234);
    cycles_to(15);
    frame_end(16'h1234);
    cycles_to(17);
    check("d0_1234", 32'(bcd_out), 32'h4);

    cycles_to(19);
    pulse_load(16'h1111);
    cycles_to(24);
    pulse_load(16'h5678);
    cycles_to(31);
    load = 1'b1; bcd_in = 16'h9999;
    frame_end(16'h9999);
    load = 1'b0;
    cycles_to(52);
    pulse_load(16'h12A4);
    cycles_to(63);
    frame_end(16'h12A4);
    cycles_to(69);
    check("d1_dark_en", 32'(digit_en), 32'h0000000F);
    check("d1_dark_nb", 32'(bcd_out),  32'h0);

    pulse_load(16'h0042);
    cycles_to(79);
    frame_end(16'h0042);
    cycles_to(86);
    check("pre_flip_en", 32'(digit_en), 32'h0000000D);
    led = 1'b0;
    cycles_to(87);
    check("post_flip_en", 32'(digit_en), 32'h00000002);
    check("post_flip_nb", 32'(bcd_out),  32'h4);
    cycles_to(100);
    pulse_load(16'h8888);
    cycles_to(104);

    reset = 1'b1; load = 1'b1; bcd_in = 16'h7777;
    tick(); tick();
    check("rst2_en",  32'(digit_en),  32'h0);
    check("rst2_bcd", 32'(bcd_out),   32'h0);
    check("rst2_idx", 32'(digit_idx), 32'h0);
    check("rst2_err", 32'(bcd_err),   32'h0);
    reset = 1'b0; load = 1'b0;
    k = 0; exp_val = 16'h0; exp_err = 1'b0;
    cycles_to(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ask4_bcd_display_mux.md
# ask4_bcd_display_mux

Time-multiplexed 4-digit scan driver that sits directly upstream of the BCD-to-7-segment decoder. It holds a 16-bit packed BCD value and cycles through the four digits. For each digit it presents one nibble on `bcd_out`, which drives the decoder's `bcd` input, and asserts exactly one digit-enable line. New values are double-buffered and committed only at frame boundaries, so a displayed frame never mixes old and new digits.

## Interface
- `REFRESH_DIV`, default 4: clock cycles each digit stays selected. Legal range 2..65535. Frame length = 4*REFRESH_DIV cycles.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `bcd_in` input 16: packed BCD value; [3:0] is digit 0 (least significant), [15:12] is digit 3.
- `load` input 1: single-cycle strobe; captures `bcd_in` into the pending buffer.
- `LED_type_ctl` input 1: display type. 1 = common cathode, so digit enables are active-low. 0 = common anode, so digit enables are active-high. The same signal also feeds the decoder.
- `bcd_out` output 4: nibble of the currently selected digit; goes to the decoder.
- `digit_en` output 4: one-hot digit select; bit n selects digit n; polarity set by `LED_type_ctl`.
- `digit_idx` output 2: index of the digit currently driven on `bcd_out`/`digit_en`.
- `bcd_err` output 1: high while the committed value contains any nibble > 9.

## Operation
- Prescaler `pcnt` counts 0..REFRESH_DIV-1 and wraps. Terminal count (TC) = `pcnt`==REFRESH_DIV-1.
- Scan index `idx` advances 0→1→2→3→0 on each TC.
- Frame boundary (FB) = TC while `idx`==3.
- Pending buffer:
  - `load`=1 writes `bcd_in` to `pend` and sets `pend_v`.
  - A later `load` before FB overwrites `pend`; only the last value is kept.
- Commit at FB:
  - If `pend_v`, then `shadow`<=`pend` and `pend_v` is cleared.
  - If `load`=1 in the same cycle as FB, `bcd_in` goes straight to `shadow` (bypass) and `pend_v` ends 0.
- `bcd_err` is recomputed from the value written to `shadow` at each commit. It otherwise holds.
- Per-digit output for digit d = `shadow`[4d+3:4d]:
  - Invalid nibble (>9): digit is dark (`digit_en` all inactive) and `bcd_out`=4'h0.
  - Blanked digit (see Configuration): same dark behaviour.
  - Otherwise: `bcd_out`=nibble and `digit_en` bit d is active.
- Polarity:
  - active level = ~`LED_type_ctl`; inactive level = `LED_type_ctl`.
  - A change on `LED_type_ctl` takes effect on the next registered update and does not disturb scanning.

## Timing
- `bcd_out`, `digit_en`, `digit_idx` and `bcd_err` are registered.
- `bcd_out`, `digit_en` and `digit_idx` reflect the `idx`/`shadow` state with exactly 1 cycle latency.
- Reset values, with `reset` high at a rising edge:
  - `pcnt`=0, `idx`=0, `pend`=0, `pend_v`=0, `shadow`=0.
  - `bcd_out`=4'h0, `digit_idx`=0, `bcd_err`=0.
  - `digit_en` = all inactive for the current `LED_type_ctl`: 4'b1111 if 1, 4'b0000 if 0.
- First cycle after reset release: outputs show digit 0 of `shadow`=0000, with bit 0 active. Each digit then stays selected for REFRESH_DIV cycles.
- Reset mid-frame aborts the scan and discards `pend`. No partial commit occurs.
- `load` during reset is ignored.
- Load-to-display latency: the value becomes visible on the cycle after the next FB, i.e. at most 4*REFRESH_DIV+1 cycles after `load`.

## Configuration
- `ASK4_LZB_EN`: leading-zero blanking.
  - Defined: digit 3 is blanked if its nibble is 0. Digit 2 is blanked if it and all higher digits are 0. Digit 1 likewise. Digit 0 is never blanked, so 0000 shows a single "0".
  - Undefined: no blanking; all valid digits are driven, including leading zeros.

## Test plan
- Reset, REFRESH_DIV=4, `LED_type_ctl`=1: during reset `digit_en`=1111, `bcd_out`=0. After release, `digit_en` follows 1110,1101,1011,0111, each for 4 cycles, then repeats.
- `load` with `bcd_in`=16'h1234 mid-frame: the current frame still shows 0000. From the cycle after FB, digit0..3 show 4,3,2,1.
- Two loads in one frame (16'h1111 then 16'h5678), plus a `load` coincident with FB carrying 16'h9999: only 5678 or 9999 commits as specified. The coincident load lands directly, so 9999 is displayed in the next frame.
- `bcd_in`=16'h12A4 committed: `bcd_err`=1 and digit 1 is dark. Committing 16'h0042 clears `bcd_err`.
- With `ASK4_LZB_EN`, commit 16'h0042: digits 3 and 2 are dark, digits 1 and 0 show 4 and 2. Without the macro, all four digits are lit and show 0,0,4,2.
- Toggle `LED_type_ctl` to 0 mid-scan: the next output cycle flips `digit_en` polarity (e.g. 1101→0010), with no change to `idx` or `bcd_out`.
